map_rle_reader: RTL
===================

# map_rle_reader

Reads back the 640x480 occupancy map that the rangefinder writes into the VGA map BRAM and streams it to the processing system as run-length-encoded words. It sits on a spare read port of the map BRAM, in the 100 MHz domain, opposite the rangefinder write port. It scans the frame in raster order and classifies each pixel as free (byte == 0) or occupied (byte != 0). It emits one word per run under a valid/ready handshake, stalling the scan on backpressure.

## Interface
- H_PIXELS, 640, pixels per line
- V_PIXELS, 480, lines per frame; frame size N = H_PIXELS*V_PIXELS, N <= 2^19
- ADDR_W, 19, BRAM address width
- clk  in  1  100 MHz system clock; all logic on rising edge
- reset  in  1  asynchronous, active-high; clears all state
- start  in  1  single-cycle pulse; begins a frame scan when idle
- busy  out  1  high from the cycle after an accepted start until done
- done  out  1  single-cycle pulse after the final word handshakes
- rd_addr  out  ADDR_W  BRAM read address
- rd_en  out  1  BRAM read enable
- rd_data  in  8  BRAM read data; fixed 1-cycle latency after rd_addr/rd_en
- m_data  out  32  run word: [31] last, [30] occ, [29:19] zero, [18:0] run length (>= 1)
- m_valid  out  1  m_data valid
- m_ready  in  1  consumer accepts; handshake completes when m_valid && m_ready

## Operation
- States:
  - IDLE: start -> SCAN; start while not IDLE ignored.
  - SCAN: issue reads at addresses 0..N-1 in order, one per cycle when not stalled. After the read of N-1 is issued -> DRAIN.
  - DRAIN: wait for the final pixel, emit the final word with last=1 -> WAIT_ACK.
  - WAIT_ACK: on the final handshake -> IDLE, pulse done.
- Run accumulator:
  - First pixel seeds occ and sets len=1.
  - Each later pixel with the same class increments len.
  - A pixel with a different class closes the run: emit {0, occ, 0, len}, then reseed with the new pixel.
- The final run is always emitted with last=1. Runs never span frames. A uniform frame yields exactly one word with len=N.
- Run lengths sum to N exactly. Classes alternate between consecutive words.
- Output register holds one word:
  - If a run closes while m_valid && !m_ready, the scan stalls: rd_en low, rd_addr held.
  - A 1-entry skid register captures the read already in flight, so no pixel is lost or duplicated for any m_ready pattern.
- m_data and m_valid are stable while m_valid && !m_ready.
- rd_en is low outside SCAN and during stalls.
- BRAM contents changing mid-scan is not detected; the words reflect the values read.
- Reset (any state) -> IDLE. Reset values:
  - rd_addr=0, rd_en=0
  - m_valid=0, m_data=0
  - busy=0, done=0
  - accumulator cleared
  - a partial frame is discarded, with no last word.

## Timing
- start sampled high at edge of cycle 0.
- busy=1 from cycle 1.
- rd_addr=a, rd_en=1 during cycle a+1. rd_data for a is valid in cycle a+2.
- With m_ready held 1 (no stalls):
  - Full throughput of 1 pixel/cycle.
  - A run ending at pixel a < N-1 raises m_valid in cycle a+4, for one cycle.
  - The final word raises m_valid in cycle N+3.
- done pulses in the cycle after the final handshake. busy falls in the same cycle.
- Each cycle of m_ready=0 while a word is pending delays all later events by exactly one cycle once the word is pending and a new run closes.
- A start pulse coincident with done is ignored. A start in the cycle after done begins a new scan.

## Test plan
- H_PIXELS=8, V_PIXELS=4, all bytes 0, m_ready=1 -> single word 0x80000020 in cycle 35, done in cycle 36.
- Same size, only address 0 = 0x7F -> words 0x40000001, then 0x8000001F.
- Same size, addresses 0..3 = 1,0,1,1, rest 0 -> 0x40000001, 0x00000001, 0x40000002, 0x8000001C.
- Random map with m_ready random at 30% -> word sequence identical to the m_ready=1 run, lengths sum to 32, no rd_addr skipped or repeated.
- Reset asserted mid-SCAN at address 10 -> all outputs at reset values immediately, no last word. A new start rescans from address 0.
- start pulsed again during SCAN and on the done cycle -> ignored; exactly one frame of words.
- Default 640x480 all zero -> one word 0x8004B000, done in cycle 307204.

Source files
------------

// File: rtl/map_rle_reader.sv
// Raster-scans the occupancy map BRAM and streams free/occupied runs as
// 32-bit run-length words over a valid/ready handshake.
module map_rle_reader #(
  parameter int H_PIXELS = 640,
  parameter int V_PIXELS = 480,
  parameter int ADDR_W   = 19
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W-1:0] rd_addr,
  output logic              rd_en,
  input  logic [7:0]        rd_data,
  output logic [31:0]       m_data,
  output logic              m_valid,
  input  logic              m_ready
);

  localparam int N     = H_PIXELS * V_PIXELS;
  localparam int PAD_W = 30 - ADDR_W;
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(N - 1);
  localparam logic [ADDR_W-1:0] ONE_LEN   = ADDR_W'(1);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    SCAN     = 2'd1,
    DRAIN    = 2'd2,
    WAIT_ACK = 2'd3
  } state_t;

  state_t            state_r;
  logic              busy_r;
  logic              done_r;
  logic [ADDR_W-1:0] rd_addr_r;
  logic              rd_en_r;
  logic [31:0]       m_data_r;
  logic              m_valid_r;
  logic              pix_vld_r;
  logic              skid_vld_r;
  logic              skid_occ_r;
  logic              acc_vld_r;
  logic              acc_occ_r;
  logic [ADDR_W-1:0] acc_len_r;

  logic src_vld_s;
  logic src_occ_s;
  logic slot_free_s;
  logic closes_s;
  logic stall_s;
  logic take_s;
  logic rd_en_s;
  logic drained_s;

  function automatic logic [31:0] run_word(input logic last, input logic occ,
                                           input logic [ADDR_W-1:0] len);
    return {last, occ, {PAD_W{1'b0}}, len};
  endfunction

  assign busy    = busy_r;
  assign done    = done_r;
  assign rd_addr = rd_addr_r;
  assign rd_en   = rd_en_s;
  assign m_data  = m_data_r;
  assign m_valid = m_valid_r;

  // Pixel source select and stall decision; a stalled pixel is parked in the skid
  // register and the read issued this cycle is suppressed so nothing else is in flight.
  always_comb begin
    src_vld_s   = skid_vld_r | pix_vld_r;
    if (skid_vld_r) begin
      src_occ_s = skid_occ_r;
    end else begin
      src_occ_s = (rd_data != 8'd0);
    end
    slot_free_s = !m_valid_r || m_ready;
    closes_s    = src_vld_s && acc_vld_r && (src_occ_s != acc_occ_r);
    stall_s     = closes_s && !slot_free_s;
    take_s      = src_vld_s && !stall_s;
    rd_en_s     = rd_en_r && !stall_s;
    drained_s   = !pix_vld_r && !skid_vld_r;
  end

  // Scan FSM, run accumulator, skid register and output word register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r    <= IDLE;
      busy_r     <= 1'b0;
      done_r     <= 1'b0;
      rd_addr_r  <= '0;
      rd_en_r    <= 1'b0;
      m_data_r   <= 32'd0;
      m_valid_r  <= 1'b0;
      pix_vld_r  <= 1'b0;
      skid_vld_r <= 1'b0;
      skid_occ_r <= 1'b0;
      acc_vld_r  <= 1'b0;
      acc_occ_r  <= 1'b0;
      acc_len_r  <= '0;
    end else begin
      done_r    <= 1'b0;
      pix_vld_r <= rd_en_s;
      if (m_valid_r && m_ready) begin
        m_valid_r <= 1'b0;
      end

      case (state_r)
        IDLE: begin
          // the cycle carrying done is still IDLE, but a start there is ignored
          if (start && !done_r) begin
            state_r    <= SCAN;
            busy_r     <= 1'b1;
            rd_en_r    <= 1'b1;
            rd_addr_r  <= '0;
            acc_vld_r  <= 1'b0;
            skid_vld_r <= 1'b0;
          end
        end
        SCAN: begin
          if (rd_en_s) begin
            if (rd_addr_r == LAST_ADDR) begin
              rd_en_r <= 1'b0;
              state_r <= DRAIN;
            end else begin
              rd_addr_r <= rd_addr_r + ONE_LEN;
            end
          end
        end
        DRAIN: begin
          if (drained_s && slot_free_s) begin
            m_data_r  <= run_word(1'b1, acc_occ_r, acc_len_r);
            m_valid_r <= 1'b1;
            state_r   <= WAIT_ACK;
          end
        end
        WAIT_ACK: begin
          if (m_valid_r && m_ready) begin
            state_r <= IDLE;
            busy_r  <= 1'b0;
            done_r  <= 1'b1;
          end
        end
        default: begin
          state_r <= IDLE;
        end
      endcase

      if (take_s) begin
        if (closes_s) begin
          m_data_r  <= run_word(1'b0, acc_occ_r, acc_len_r);
          m_valid_r <= 1'b1;
          acc_occ_r <= src_occ_s;
          acc_len_r <= ONE_LEN;
        end else if (acc_vld_r) begin
          acc_len_r <= acc_len_r + ONE_LEN;
        end else begin
          acc_vld_r <= 1'b1;
          acc_occ_r <= src_occ_s;
          acc_len_r <= ONE_LEN;
        end
      end

      if (stall_s && !skid_vld_r) begin
        skid_vld_r <= 1'b1;
        skid_occ_r <= src_occ_s;
      end else if (take_s && skid_vld_r) begin
        skid_vld_r <= 1'b0;
      end
    end
  end

endmodule
